ser_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one `serializer` instance among `NUM_REQ` requesters. Each requester presents a complete frame (payload, width, depth). The scheduler grants one requester, latches its frame and launches the serializer with a one-cycle start pulse. It waits for the serializer's done, acknowledges the requester, then enforces a programmable inter-frame gap. It sits between the FEC encoder output queues and the TX serializer.

---
 rtl/ser_tx_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_ser_tx_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ser_tx_scheduler
// Round-robin scheduler sharing one TX serializer among NUM_REQ requesters.
// A granted requester's frame (payload, last bit index, last sample index) is
// latched, the serializer is launched with a one-cycle start pulse, and after
// the serializer's done pulse the requester gets a one-cycle ack. A
// programmable idle gap follows each frame before the next grant.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : allows new grants (looked at only while idle)
//   req            : level request per requester, held until its ack
//   req_data       : frame payload per requester
//   req_width      : last bit index per requester
//   req_depth      : last sample index per requester
//   cfg_clk_div    : serializer divider, captured at grant
//   cfg_gap        : idle cycles after each frame, captured at done
//   ser_start      : one-cycle launch pulse to the serializer
//   ser_par_in     : latched payload
//   ser_width/ser_depth/ser_clk_div : latched frame configuration
//   ser_done       : serializer completion pulse
//   grant          : one-hot, launch through done cycle
//   ack            : one-cycle completion pulse to the granted requester
//   active_id      : index of the current or last grant
//   busy           : high whenever not idle
//   frame_count    : completed frames, wraps
// ---------------------------------------------------------------------------
module ser_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int GAP_WIDTH  = 8,
  parameter int FCNT_WIDTH = 16,
  localparam int WW  = $clog2(DATA_WIDTH) + 1,
  localparam int DW  = $clog2(DATA_DEPTH) + 1,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           en,
  input  logic [NUM_REQ-1:0]                             req,
  input  logic [NUM_REQ-1:0][DATA_DEPTH-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0][WW-1:0]                     req_width,
  input  logic [NUM_REQ-1:0][DW-1:0]                     req_depth,
  input  logic [DIV_WIDTH-1:0]                           cfg_clk_div,
  input  logic [GAP_WIDTH-1:0]                           cfg_gap,
  output logic                                           ser_start,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]          ser_par_in,
  output logic [WW-1:0]                                  ser_width,
  output logic [DW-1:0]                                  ser_depth,
  output logic [DIV_WIDTH-1:0]                           ser_clk_div,
  input  logic                                           ser_done,
  output logic [NUM_REQ-1:0]                             grant,
  output logic [NUM_REQ-1:0]                             ack,
  output logic [IDW-1:0]                                 active_id,
  output logic                                           busy,
  output logic [FCNT_WIDTH-1:0]                          frame_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE = {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]  GAP_ZERO = {GAP_WIDTH{1'b0}};
  localparam logic [IDW-1:0]        ID_LAST  = IDW'(NUM_REQ - 1);

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [1:0]                              r_state;
  logic                                    r_busy;
  logic                                    r_start;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]   r_par;
  logic [WW-1:0]                           r_width;
  logic [DW-1:0]                           r_depth;
  logic [DIV_WIDTH-1:0]                    r_clk_div;
  logic [NUM_REQ-1:0]                      r_grant;
  logic [NUM_REQ-1:0]                      r_ack;
  logic [IDW-1:0]                          r_active_id;
  logic [FCNT_WIDTH-1:0]                   r_fcnt;
  logic [GAP_WIDTH-1:0]                    r_gap_cnt;

  logic [IDW-1:0]                          w_sel_idx;
  logic                                    w_sel_vld;
  logic [IDW-1:0]                          w_cand;
  logic                                    w_hit;

  // Round-robin pick: first set request scanning upward from the last grant,
  // so the most recently served requester always ranks last.
  always_comb begin
    w_sel_idx = r_active_id;
    w_sel_vld = 1'b0;
    w_cand    = r_active_id;
    w_hit     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand    = IDW'((int'(r_active_id) + i) % NUM_REQ);
      w_hit     = req[w_cand];
      w_sel_idx = (w_hit && !w_sel_vld) ? w_cand : w_sel_idx;
      w_sel_vld = w_sel_vld | w_hit;
    end
  end

  // Scheduler state machine and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_par       <= '0;
      r_width     <= '0;
      r_depth     <= '0;
      r_clk_div   <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_active_id <= ID_LAST;
      r_fcnt      <= '0;
      r_gap_cnt   <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one cycle below.
      r_start <= 1'b0;
      r_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (en && w_sel_vld) begin
            r_par       <= req_data[w_sel_idx];
            r_width     <= req_width[w_sel_idx];
            r_depth     <= req_depth[w_sel_idx];
            r_clk_div   <= cfg_clk_div;
            r_grant     <= onehot(w_sel_idx);
            r_active_id <= w_sel_idx;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (ser_done) begin
            r_ack     <= onehot(r_active_id);
            r_grant   <= '0;
            r_fcnt    <= r_fcnt + FCNT_ONE;
            r_gap_cnt <= cfg_gap;
            if (cfg_gap == GAP_ZERO) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_GAP;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_ONE;
          // Leaving on a count of one gives exactly cfg_gap cycles here;
          // the <= also guards against a zero count ever sticking.
          if (r_gap_cnt <= GAP_ONE) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_busy  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ser_start   = r_start;
  assign ser_par_in  = r_par;
  assign ser_width   = r_width;
  assign ser_depth   = r_depth;
  assign ser_clk_div = r_clk_div;
  assign grant       = r_grant;
  assign ack         = r_ack;
  assign active_id   = r_active_id;
  assign busy        = r_busy;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
module tb_ser_tx_scheduler;

  localparam int NR = 4;
  localparam int FW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    en;
  logic [3:0]              req;
  logic [3:0][3:0][31:0]   req_data;
  logic [3:0][5:0]         req_width;
  logic [3:0][2:0]         req_depth;
  logic [7:0]              cfg_clk_div;
  logic [7:0]              cfg_gap;
  logic                    ser_start;
  logic [3:0][31:0]        ser_par_in;
  logic [5:0]              ser_width;
  logic [2:0]              ser_depth;
  logic [7:0]              ser_clk_div;
  logic                    ser_done;
  logic [3:0]              grant;
  logic [3:0]              ack;
  logic [1:0]              active_id;
  logic                    busy;
  logic [FW-1:0]           frame_count;

  ser_tx_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(32), .DATA_DEPTH(4), .DIV_WIDTH(8),
    .GAP_WIDTH(8), .FCNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_data(req_data),
    .req_width(req_width), .req_depth(req_depth), .cfg_clk_div(cfg_clk_div),
    .cfg_gap(cfg_gap), .ser_start(ser_start), .ser_par_in(ser_par_in),
    .ser_width(ser_width), .ser_depth(ser_depth), .ser_clk_div(ser_clk_div),
    .ser_done(ser_done), .grant(grant), .ack(ack), .active_id(active_id),
    .busy(busy), .frame_count(frame_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int               m_last;
  int               m_frames;
  logic [3:0][31:0] m_data [4];
  logic [5:0]       m_w [4];
  logic [2:0]       m_d [4];
  logic [7:0]       m_div;

  function automatic int next_rr(input logic [3:0] mask, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int id);
    for (int d = 0; d < 4; d++) req_data[id][d] = $urandom;
    req_width[id] = 6'($urandom_range(0, 31));
    req_depth[id] = 3'($urandom_range(0, 3));
    m_data[id] = req_data[id];
    m_w[id]    = req_width[id];
    m_d[id]    = req_depth[id];
    req[id]    = 1'b1;
  endtask

  // Serve one frame as the serializer would, checking the scheduler's side.
  // exp_wait: negedges from now until ser_start is expected (-1 = unchecked).
  task automatic serve(input int exp_id, input int exp_wait, input int lat, input int gap,
                       input logic drop_en, input logic [3:0] add_mask);
    int n;
    n = 0;
    while (ser_start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("start_seen", 128'(ser_start), 128'(1'b1));
    if (exp_wait >= 0) chk("start_delay", 128'(n), 128'(exp_wait));
    chk("grant_onehot", 128'(grant), 128'(4'b0001 << exp_id));
    chk("active_id", 128'(active_id), 128'(exp_id));
    chk("par_in_grant", 128'(ser_par_in), 128'(m_data[exp_id]));
    chk("width", 128'(ser_width), 128'(m_w[exp_id]));
    chk("depth", 128'(ser_depth), 128'(m_d[exp_id]));
    chk("clk_div_grant", 128'(ser_clk_div), 128'(m_div));
    m_last   = exp_id;
    m_frames = (m_frames + 1) % (1 << FW);
    // Inputs changing while granted must not reach the latched frame.
    req_data[exp_id][0] = ~req_data[exp_id][0];
    req_width[exp_id]   = ~req_width[exp_id];
    cfg_clk_div         = ~cfg_clk_div;
    if (drop_en) en = 1'b0;
    cfg_gap = 8'(gap);
    step();
    chk("start_one_cycle", 128'(ser_start), 128'(1'b0));
    chk("busy_wait", 128'(busy), 128'(1'b1));
    repeat (lat) step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    chk("ack_pulse", 128'(ack), 128'(4'b0001 << exp_id));
    chk("grant_cleared", 128'(grant), 128'(4'b0000));
    chk("frame_count", 128'(frame_count), 128'(m_frames));
    chk("par_in_held", 128'(ser_par_in), 128'(m_data[exp_id]));
    chk("width_held", 128'(ser_width), 128'(m_w[exp_id]));
    chk("clk_div_held", 128'(ser_clk_div), 128'(m_div));
    chk("busy_after_done", 128'(busy), 128'(gap != 0));
    req[exp_id] = 1'b0;
    cfg_gap     = 8'($urandom);
    m_div       = 8'($urandom);
    cfg_clk_div = m_div;
    for (int k = 0; k < NR; k++) begin
      if (add_mask[k] && !req[k]) set_req(k);
    end
    step();
    chk("ack_cleared", 128'(ack), 128'(4'b0000));
  endtask

  initial begin
    int e;
    int w;
    int g;
    logic [3:0] mask;
    rst_n = 1'b0; en = 1'b1; req = '0; req_data = '0; req_width = '0; req_depth = '0;
    ser_done = 1'b0; cfg_gap = 8'd0; m_div = 8'd0; cfg_clk_div = 8'd0;
    m_last = NR - 1; m_frames = 0;

    // Reset state
    step(); step();
    chk("rst_start", 128'(ser_start), 128'(1'b0));
    chk("rst_grant", 128'(grant), 128'(4'b0000));
    chk("rst_ack", 128'(ack), 128'(4'b0000));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_fcnt", 128'(frame_count), 128'(0));
    chk("rst_par", 128'(ser_par_in), 128'(0));
    chk("rst_active_id", 128'(active_id), 128'(NR - 1));
    rst_n = 1'b1;
    step();

    // Fairness: all four held, each drops after its ack -> 0,1,2,3 twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NR; k++) set_req(k);
      for (int k = 0; k < NR; k++) serve(k, (k == 0) ? 1 : 0, $urandom_range(0, 4), 0, 1'b0, 4'b0000);
    end

    // Single request: width 7, depth 0, clk_div 0, gap 0
    m_div = 8'd0; cfg_clk_div = 8'd0;
    set_req(0);
    req_width[0] = 6'd7; req_depth[0] = 3'd0; m_w[0] = 6'd7; m_d[0] = 3'd0;
    serve(0, 1, 3, 0, 1'b0, 4'b0000);

    // Gap of 5 between two pending requests
    set_req(0); set_req(1);
    serve(next_rr(req, m_last), 1, 2, 5, 1'b0, 4'b0000);
    serve(next_rr(req, m_last), 5, 2, 0, 1'b0, 4'b0000);

    // Enable dropped mid-frame: frame completes, no further grant while low
    set_req(1); set_req(2);
    serve(next_rr(req, m_last), 1, 4, 0, 1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("en_low_no_start", 128'(ser_start), 128'(1'b0));
      chk("en_low_no_grant", 128'(grant), 128'(4'b0000));
      chk("en_low_idle", 128'(busy), 128'(1'b0));
    end
    // A stray done while idle must be ignored
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    chk("stray_done_ack", 128'(ack), 128'(4'b0000));
    chk("stray_done_fcnt", 128'(frame_count), 128'(m_frames));
    en = 1'b1;
    serve(next_rr(req, m_last), 1, 1, 0, 1'b0, 4'b0000);

    // Asynchronous reset during S_WAIT
    set_req(0);
    step();
    chk("pre_rst_start", 128'(ser_start), 128'(1'b1));
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 128'(ser_start), 128'(1'b0));
    chk("arst_grant", 128'(grant), 128'(4'b0000));
    chk("arst_busy", 128'(busy), 128'(1'b0));
    chk("arst_fcnt", 128'(frame_count), 128'(0));
    chk("arst_par", 128'(ser_par_in), 128'(0));
    chk("arst_cfg", 128'({ser_width, ser_depth, ser_clk_div}), 128'(0));
    chk("arst_active_id", 128'(active_id), 128'(NR - 1));
    req = '0;
    step(); step();
    rst_n = 1'b1;
    m_last = NR - 1; m_frames = 0;
    m_div = 8'($urandom); cfg_clk_div = m_div;
    set_req(3);
    serve(next_rr(req, m_last), 1, 2, 0, 1'b0, 4'b0000);

    // Randomized traffic against the round-robin model (wraps frame_count)
    set_req($urandom_range(0, 3));
    w = 1;
    for (int t = 0; t < 40; t++) begin
      e    = next_rr(req, m_last);
      g    = $urandom_range(0, 6);
      mask = 4'($urandom) | (4'b0001 << ((e + 1 + $urandom_range(0, 2)) % NR));
      serve(e, w, $urandom_range(0, 5), g, 1'b0, mask);
      if (m_frames == 0) chk("fcnt_wrap", 128'(frame_count), 128'(0));
      w = g;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
